// File: rtl/fc_pkg.sv
// Shared types and defaults for the fully-connected classification controller.
package fc_pkg;

    localparam int unsigned NUM_CLASSES_DEF = 10;
    localparam int unsigned IN_LEN_DEF      = 16;
    localparam int unsigned DATA_W_DEF      = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_ACCUM,
        ST_WAIT,
        ST_SCAN,
        ST_OUT
    } fc_ctrl_state_t;

    // Index width for a memory of the given depth; never narrower than one bit.
    function automatic int unsigned addr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int unsigned CLS_W_DEF = addr_w(NUM_CLASSES_DEF);

endpackage

// File: rtl/fc_argmax_scan.sv
// Sequential argmax over the score buffer: one signed compare per cycle, ties keep the lowest index.
module fc_argmax_scan
    import fc_pkg::*;
#(
    parameter int unsigned NUM_CLASSES = NUM_CLASSES_DEF,
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned CLS_W       = addr_w(NUM_CLASSES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [CLS_W-1:0]  rd_idx,
    input  logic [DATA_W-1:0] rd_score,
    output logic              done_c,
    output logic [CLS_W-1:0]  max_idx,
    output logic [DATA_W-1:0] max_score
);

    localparam logic [CLS_W-1:0] IDX_LAST = CLS_W'(NUM_CLASSES - 1);

    logic             active;
    logic [CLS_W-1:0] idx;

    // idx rests at 0 while idle, so the start cycle reads score[0] as the seed.
    assign rd_idx = idx;
    assign done_c = active && (idx == IDX_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            active    <= 1'b0;
            idx       <= '0;
            max_idx   <= '0;
            max_score <= '0;
        end else if (start) begin
            active    <= 1'b1;
            idx       <= CLS_W'(1);
            max_idx   <= '0;
            max_score <= rd_score;
        end else if (active) begin
            if ($signed(rd_score) > $signed(max_score)) begin
                max_idx   <= idx;
                max_score <= rd_score;
            end
            if (idx == IDX_LAST) begin
                active <= 1'b0;
                idx    <= '0;
            end else begin
                idx <= idx + CLS_W'(1);
            end
        end
    end

endmodule

// File: rtl/fc_classify_ctrl.sv
// Sequencer for the FC classification stage: per-class MAC dot products, score capture,
// argmax scan and a valid/ready result port.
module fc_classify_ctrl
    import fc_pkg::*;
#(
    parameter int unsigned NUM_CLASSES = NUM_CLASSES_DEF,
    parameter int unsigned IN_LEN      = IN_LEN_DEF,
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned CLS_W       = addr_w(NUM_CLASSES)
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   start,
    output logic                                   busy,
    output logic [addr_w(IN_LEN)-1:0]              feat_addr,
    output logic [addr_w(NUM_CLASSES*IN_LEN)-1:0]  wgt_addr,
    output logic                                   mac_clr,
    output logic                                   mac_en,
    output logic                                   mac_last,
    input  logic                                   acc_valid,
    input  logic [DATA_W-1:0]                      acc_data,
    output logic                                   result_valid,
    input  logic                                   result_ready,
    output logic [CLS_W-1:0]                       result_class,
    output logic [DATA_W-1:0]                      result_score
);

    localparam int unsigned FEAT_W = addr_w(IN_LEN);
    localparam int unsigned WGT_W  = addr_w(NUM_CLASSES * IN_LEN);
    localparam logic [FEAT_W-1:0] K_LAST = FEAT_W'(IN_LEN - 1);
    localparam logic [CLS_W-1:0]  J_LAST = CLS_W'(NUM_CLASSES - 1);

    fc_ctrl_state_t    state, state_nxt;
    logic [CLS_W-1:0]  j, j_nxt;
    logic [FEAT_W-1:0] k, k_nxt;
    logic              clr_nxt, en_nxt, last_nxt, valid_nxt;
    logic [FEAT_W-1:0] feat_nxt;
    logic [WGT_W-1:0]  wgt_nxt;
    logic [WGT_W-1:0]  row_base;
    logic              capture_c, scan_start_c, scan_done_c;
    logic [CLS_W-1:0]  scan_idx;
    logic [DATA_W-1:0] score [NUM_CLASSES];

    assign row_base = WGT_W'(j) * WGT_W'(IN_LEN);

    // Next state plus next values of the registered strobes and addresses.
    always_comb begin
        state_nxt    = state;
        j_nxt        = j;
        k_nxt        = k;
        clr_nxt      = 1'b0;
        en_nxt       = 1'b0;
        last_nxt     = 1'b0;
        valid_nxt    = 1'b0;
        feat_nxt     = '0;
        wgt_nxt      = '0;
        capture_c    = 1'b0;
        scan_start_c = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_CLEAR;
                    j_nxt     = '0;
                    clr_nxt   = 1'b1;
                end
            end
            ST_CLEAR: begin
                state_nxt = ST_ACCUM;
                k_nxt     = '0;
                en_nxt    = 1'b1;
                wgt_nxt   = row_base;
                last_nxt  = (K_LAST == '0);
            end
            ST_ACCUM: begin
                if (k == K_LAST) begin
                    state_nxt = ST_WAIT;
                end else begin
                    k_nxt    = k + FEAT_W'(1);
                    en_nxt   = 1'b1;
                    feat_nxt = k_nxt;
                    wgt_nxt  = row_base + WGT_W'(k_nxt);
                    last_nxt = (k_nxt == K_LAST);
                end
            end
            ST_WAIT: begin
                if (acc_valid) begin
                    capture_c = 1'b1;
                    if (j == J_LAST) begin
                        state_nxt    = ST_SCAN;
                        scan_start_c = 1'b1;
                    end else begin
                        state_nxt = ST_CLEAR;
                        j_nxt     = j + CLS_W'(1);
                        clr_nxt   = 1'b1;
                    end
                end
            end
            ST_SCAN: begin
                if (scan_done_c) begin
                    state_nxt = ST_OUT;
                    valid_nxt = 1'b1;
                end
            end
            ST_OUT: begin
                if (result_ready) begin
                    state_nxt = ST_IDLE;
                end else begin
                    valid_nxt = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= ST_IDLE;
            j            <= '0;
            k            <= '0;
            busy         <= 1'b0;
            mac_clr      <= 1'b0;
            mac_en       <= 1'b0;
            mac_last     <= 1'b0;
            feat_addr    <= '0;
            wgt_addr     <= '0;
            result_valid <= 1'b0;
        end else begin
            state        <= state_nxt;
            j            <= j_nxt;
            k            <= k_nxt;
            busy         <= (state_nxt != ST_IDLE);
            mac_clr      <= clr_nxt;
            mac_en       <= en_nxt;
            mac_last     <= last_nxt;
            feat_addr    <= feat_nxt;
            wgt_addr     <= wgt_nxt;
            result_valid <= valid_nxt;
        end
    end

    // Score buffer is deliberately left out of reset; every entry is rewritten each run.
    always_ff @(posedge clk) begin
        if (reset && capture_c) begin
            score[j] <= acc_data;
        end
    end

    fc_argmax_scan #(
        .NUM_CLASSES (NUM_CLASSES),
        .DATA_W      (DATA_W),
        .CLS_W       (CLS_W)
    ) u_scan (
        .clk       (clk),
        .reset     (reset),
        .start     (scan_start_c),
        .rd_idx    (scan_idx),
        .rd_score  (score[scan_idx]),
        .done_c    (scan_done_c),
        .max_idx   (result_class),
        .max_score (result_score)
    );

endmodule

// File: tb/tb_fc_classify_ctrl.sv
// Scoreboard bench for fc_classify_ctrl with a behavioural MAC returning directed class scores.
module tb_fc_classify_ctrl;

    localparam int NC  = 10;
    localparam int IL  = 4;
    localparam int LAT = 2;
    localparam int EXP_LAT = 1 + NC * (1 + IL + LAT) + (NC - 1);

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        busy;
    logic [1:0]  feat_addr;
    logic [5:0]  wgt_addr;
    logic        mac_clr, mac_en, mac_last;
    logic        acc_valid;
    logic [15:0] acc_data;
    logic        result_valid;
    logic        result_ready;
    logic [3:0]  result_class;
    logic [15:0] result_score;

    always #5 clk = ~clk;

    fc_classify_ctrl #(.NUM_CLASSES(NC), .IN_LEN(IL), .DATA_W(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .busy         (busy),
        .feat_addr    (feat_addr),
        .wgt_addr     (wgt_addr),
        .mac_clr      (mac_clr),
        .mac_en       (mac_en),
        .mac_last     (mac_last),
        .acc_valid    (acc_valid),
        .acc_data     (acc_data),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result_class (result_class),
        .result_score (result_score)
    );

    typedef struct {
        int cls;
        int score;
        int start_cyc;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   scores [NC];
    bit   spur     = 1'b0;
    int   clr_in_run = 0;
    int   en_in_run  = 0;
    int   k_exp      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint got, input longint exp_v);
        n_checks++;
        if (got != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, got, exp_v, cyc);
        end
    endtask

    task automatic fail_now(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event missing or unexpected (cycle %0d)", nm, cyc);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // MAC model: acc_valid LAT cycles after mac_last, with optional spurious pulses.
    int pend = 0;
    int pend_cls = 0;
    always @(negedge clk) begin
        acc_valid = 1'b0;
        if (!reset) begin
            pend = 0;
        end else begin
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    acc_valid = 1'b1;
                    acc_data  = 16'(scores[pend_cls]);
                end
            end
            if (mac_last) begin
                pend     = LAT;
                pend_cls = int'(wgt_addr) / IL;
            end
            if (spur && !acc_valid && ((mac_en && feat_addr == 2'd1) || !busy)) begin
                acc_valid = 1'b1;
                acc_data  = 16'h7FFF;
            end
        end
    end

    // Address / strobe checker.
    always @(negedge clk) begin
        if (reset) begin
            if (mac_clr) begin
                clr_in_run++;
                k_exp = 0;
                chk("clr_with_en", longint'(mac_en), 0);
            end
            if (mac_en) begin
                chk("feat_addr", longint'(feat_addr), k_exp);
                chk("wgt_addr", longint'(wgt_addr), (clr_in_run - 1) * IL + k_exp);
                chk("mac_last", longint'(mac_last), longint'(k_exp == IL - 1));
                en_in_run++;
                k_exp++;
            end else if (mac_last) begin
                chk("mac_last_stray", longint'(mac_last), 0);
            end
        end
    end

    // Result monitor: checks every valid cycle against the head of the scoreboard.
    bit rv_q = 1'b0;
    always @(negedge clk) begin
        if (result_valid) begin
            if (q.size() == 0) begin
                if (!rv_q) fail_now("unexpected_result");
            end else begin
                if (!rv_q) chk("latency", cyc - q[0].start_cyc, EXP_LAT);
                chk("result_class", longint'(result_class), q[0].cls);
                chk("result_score", longint'($signed(result_score)), q[0].score);
            end
        end
        if (rv_q && result_ready) begin
            if (q.size() != 0) q.delete(0);
            chk("valid_after_xfer", longint'(result_valid), 0);
        end
        rv_q = result_valid;
    end

    task automatic wait_done(input int bound);
        int n = 0;
        while (q.size() != 0 && n < bound) begin
            tick();
            n++;
        end
        if (q.size() != 0) begin
            fail_now("result_timeout");
            q.delete();
        end
        tick();
        chk("idle_after_xfer", longint'(busy), 0);
    endtask

    task automatic issue_start(input int exp_cls, input int exp_score);
        clr_in_run = 0;
        en_in_run  = 0;
        q.push_back('{exp_cls, exp_score, cyc});
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", longint'(busy), 1);
        chk("first_clr", longint'(mac_clr), 1);
    endtask

    task automatic run_one(input int exp_cls, input int exp_score);
        issue_start(exp_cls, exp_score);
        wait_done(300);
        chk("clear_count", clr_in_run, NC);
        chk("enable_count", en_in_run, NC * IL);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},     longint'(busy), 0);
        chk({tag, "_mac_clr"},  longint'(mac_clr), 0);
        chk({tag, "_mac_en"},   longint'(mac_en), 0);
        chk({tag, "_mac_last"}, longint'(mac_last), 0);
        chk({tag, "_feat"},     longint'(feat_addr), 0);
        chk({tag, "_wgt"},      longint'(wgt_addr), 0);
        chk({tag, "_valid"},    longint'(result_valid), 0);
        chk({tag, "_class"},    longint'(result_class), 0);
        chk({tag, "_score"},    longint'(result_score), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b0;
        start = 1'b0;
        result_ready = 1'b1;
        acc_data = '0;
        scores = '{3, -1, 7, 2, 0, 5, 6, 1, 4, -8};
        repeat (3) tick();
        chk_all_zero("reset");
        reset = 1'b1;
        tick();

        // Basic, ties, all-equal maximum, unique maximum in last class.
        run_one(2, 7);
        scores = '{-5, -3, -3, -9, -9, -9, -9, -9, -9, -9};
        run_one(1, -3);
        scores = '{32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767};
        run_one(0, 32767);
        scores = '{5, 5, 5, 5, 5, 5, 5, 5, 5, 6};
        run_one(9, 6);

        // Backpressure with start pulses ignored; start during the handshake also ignored.
        scores = '{3, -1, 7, 2, 0, 5, 6, 1, 4, -8};
        result_ready = 1'b0;
        issue_start(2, 7);
        n = 0;
        while (!result_valid && n < 200) begin
            tick();
            n++;
        end
        if (!result_valid) fail_now("bp_valid_timeout");
        for (int i = 0; i < 20; i++) begin
            chk("bp_busy", longint'(busy), 1);
            chk("bp_valid", longint'(result_valid), 1);
            start = (i % 3 == 0);
            tick();
        end
        start = 1'b1;
        result_ready = 1'b1;
        tick();
        start = 1'b0;
        chk("bp_idle_busy", longint'(busy), 0);
        chk("bp_idle_valid", longint'(result_valid), 0);
        tick();
        chk("bp_no_restart", longint'(busy), 0);
        chk("bp_queue_drained", q.size(), 0);

        // Reset during WAIT of class 4, then a clean rerun.
        clr_in_run = 0;
        en_in_run  = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!(clr_in_run == 5 && mac_last) && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) fail_now("class4_timeout");
        tick();
        reset = 1'b0;
        tick();
        chk_all_zero("abort");
        tick();
        reset = 1'b1;
        tick();
        chk("abort_idle", longint'(busy), 0);
        run_one(2, 7);

        // Spurious acc_valid in IDLE and ACCUM, start during SCAN.
        spur = 1'b1;
        repeat (3) tick();
        issue_start(2, 7);
        repeat (73) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(300);
        chk("spur_clear_count", clr_in_run, NC);
        chk("spur_enable_count", en_in_run, NC * IL);
        spur = 1'b0;
        repeat (3) tick();
        chk("spur_idle", longint'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fc_classify_ctrl.md
# fc_classify_ctrl

Sequencer for the fully-connected classification stage of the DCNN accelerator. It drives a shared MAC unit through one dot product per output class (feature × weight), captures each class score into an internal score buffer, runs a sequential argmax scan over the buffer, and presents the winning class index and score on a valid/ready output port. It sits between the feature/weight memories plus MAC datapath and the result consumer. It replaces ad-hoc start/enable sequencing of the argmax logic with a single controller.

## Interface
- NUM_CLASSES, 10, number of output classes (≥2)
- IN_LEN, 16, features per dot product (≥1)
- DATA_W, 16, score width, signed two's complement
- CLS_W, $clog2(NUM_CLASSES), class index width
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-low; sampled on clk
- start  in  1  begin one classification; accepted only in IDLE
- busy  out  1  high in every state except IDLE
- feat_addr  out  $clog2(IN_LEN)  feature memory address
- wgt_addr  out  $clog2(NUM_CLASSES*IN_LEN)  weight address = class*IN_LEN + k
- mac_clr  out  1  clear MAC accumulator (one cycle)
- mac_en  out  1  accumulate feature×weight at current addresses
- mac_last  out  1  marks final accumulate of a dot product
- acc_valid  in  1  MAC result ready (any latency ≥1 after mac_last)
- acc_data  in  DATA_W  MAC result, saturated to DATA_W by the MAC
- result_valid  out  1  result available
- result_ready  in  1  consumer accepts result
- result_class  out  CLS_W  argmax index
- result_score  out  DATA_W  maximum score

## Operation
- States: IDLE, CLEAR, ACCUM, WAIT, SCAN, OUT.
- IDLE: all strobes low; start=1 → CLEAR with class counter j=0.
- CLEAR: mac_clr=1 for one cycle → ACCUM, k=0.
- ACCUM: mac_en=1 each cycle for k=0..IN_LEN-1; feat_addr=k, wgt_addr=j*IN_LEN+k; mac_last=1 when k=IN_LEN-1; then → WAIT.
- WAIT: on acc_valid, score[j]←acc_data; if j=NUM_CLASSES-1 → SCAN, else j←j+1 and → CLEAR.
- SCAN: max←score[0], idx←0, then one compare per cycle for i=1..NUM_CLASSES-1; update only when score[i] > max (signed compare, strict). Ties keep the lowest index. After i=NUM_CLASSES-1 → OUT.
- OUT: result_valid=1, with result_class/result_score held stable; on result_valid&&result_ready → IDLE.
- Score buffer: NUM_CLASSES×DATA_W registers, not cleared by reset. Contents are valid only after they are written.

## Timing
- Reset values: busy=0, mac_clr=0, mac_en=0, mac_last=0, feat_addr=0, wgt_addr=0, result_valid=0, result_class=0, result_score=0; state=IDLE; counters=0.
- Reset asserted in any state aborts the operation. The next cycle is IDLE with the reset values above. No partial result is emitted.
- start→first mac_clr: 1 cycle (state registered). busy rises the cycle after start is sampled.
- Per class: 1 (CLEAR) + IN_LEN (ACCUM) + L (WAIT, L = cycles until acc_valid, ≥1).
- Total start→result_valid: 1 + NUM_CLASSES*(1+IN_LEN+L) + (NUM_CLASSES-1).
- start is ignored while busy, including in the cycle a handshake completes. A new start is accepted only from IDLE, at least 1 cycle after the handshake.
- acc_valid outside WAIT is ignored. acc_valid held high across WAIT cycles captures once.
- result_ready already high when result_valid rises → transfer in that cycle; IDLE next.
- result_ready low → OUT is held indefinitely, and outputs must not change.

## Structure
- Shared package fc_pkg: state enum type (fc_ctrl_state_t), default NUM_CLASSES/IN_LEN/DATA_W constants, CLS_W derivation.
- One natural sub-module: fc_argmax_scan. It holds the running max/idx registers and the signed compare, and has start/done and an index port into the score buffer. The FSM, counters and address generation stay in fc_classify_ctrl.

## Test plan
- Basic (IN_LEN=4, L=2): MAC model returns scores {3,-1,7,2,0,5,6,1,4,-8} → result_class=2, result_score=7; result_valid rises exactly 1+10*7+9=80 cycles after start.
- Ties/negatives: scores {-5,-3,-3,-9,…,-9} → class 1, score -3. All equal 0x7FFF → class 0. Last class unique max → class 9.
- Addressing: every ACCUM cycle wgt_addr=j*4+k, feat_addr=k; mac_clr exactly once per class; mac_last on k=3 only; 10 clears, 40 enables total.
- Backpressure: result_ready low for 20 cycles after result_valid → outputs stable, busy=1, start pulses ignored; ready high → IDLE next cycle.
- Reset mid-run: reset low during WAIT of class 4 → next cycle all outputs 0, IDLE. A fresh start then yields the correct full result.
- Spurious inputs: acc_valid pulsed during ACCUM and IDLE, start during SCAN → no score corruption and no restart; result matches the basic case.
